// File: rtl/mem_arb_pkg.sv
// Shared definitions for the line-memory arbiter.
//   arb_state_e : controller states (idle, memory busy, cool-down)
//   ADDR_W_DEF  : default line address width (byte address bits [31:4])
//   LINE_W_DEF  : default line data width
//   ARB_RR / ARB_FIXED : arbitration mode selectors
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned LINE_W_DEF = 128;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StCool
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Winner select for the line-memory arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel pending requests
//   advance    : high when the controller takes the current winner
//   gnt        : one-hot winner (combinational)
//   idx        : binary index of the winner (combinational)
//   any        : at least one request pending
// Round-robin mode searches from a registered pointer that moves past each
// taken winner; fixed mode always prefers the lowest index.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ARB_MODE = ARB_RR,
  localparam int unsigned IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NCH-1:0] req,
  input  logic          advance,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = IW'(k);
      end else begin
        cand = IW'((32'(ptr_q) + k) % NCH);
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ARB_MODE == ARB_RR && advance && any) begin
      // Next search starts just past the winner, wrapping at NCH-1.
      if (32'(idx) == NCH - 1) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one slow line-memory port among NCH cache miss channels.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ch_read / ch_write  : per-channel line read / write requests
//   ch_addr / ch_wdata  : packed per-channel line address / write line
//   ch_ready            : one-hot, one-cycle completion pulse
//   ch_rdata            : last read line, valid with ch_ready
//   mem_read/mem_write  : registered request to memory, held until mem_ready
//   mem_addr/mem_wdata  : registered address / write line to memory
//   mem_rdata/mem_ready : memory read line and completion
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LINE_W   = LINE_W_DEF,
  parameter int unsigned ARB_MODE = ARB_RR,
  localparam int unsigned IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_read,
  input  logic [NCH-1:0]        ch_write,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH*LINE_W-1:0] ch_wdata,
  output logic [NCH-1:0]        ch_ready,
  output logic [LINE_W-1:0]     ch_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  arb_state_e       state_q;
  logic [NCH-1:0]   gnt_q;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   gnt;
  logic [IW-1:0]    idx;
  logic             any;
  logic             advance;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_rd;
  logic              sel_wr;

  assign pending = ch_read | ch_write;
  assign advance = (state_q == StIdle);

  rr_pick #(
    .NCH      (NCH),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pending),
    .advance (advance),
    .gnt     (gnt),
    .idx     (idx),
    .any     (any)
  );

  always_comb begin
    sel_addr  = ch_addr[32'(idx)*ADDR_W +: ADDR_W];
    sel_wdata = ch_wdata[32'(idx)*LINE_W +: LINE_W];
    sel_wr    = ch_write[idx];
    // Write wins over a simultaneous read: write-back first, refill re-requested.
    sel_rd    = ch_read[idx] & ~ch_write[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_ready  <= '0;
      ch_rdata  <= '0;
    end else begin
      ch_ready <= '0;
      unique case (state_q)
        StIdle: begin
          if (any) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_read  <= sel_rd;
            mem_write <= sel_wr;
            gnt_q     <= gnt;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          // Channel inputs are ignored here; the memory request stays frozen.
          if (mem_ready) begin
            if (mem_read) begin
              ch_rdata <= mem_rdata;
            end
            ch_ready  <= gnt_q;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= StCool;
          end
        end
        StCool: begin
          // Dead cycle so the served channel can drop its request.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      ch_read = '0;
  logic [1:0]      ch_write = '0;
  logic [2*AW-1:0] ch_addr = '0;
  logic [2*LW-1:0] ch_wdata = '0;

  logic [1:0]    ch_ready, b_ch_ready;
  logic [LW-1:0] ch_rdata, b_ch_rdata;
  logic          mem_read, mem_write, b_mem_read, b_mem_write;
  logic [AW-1:0] mem_addr, b_mem_addr;
  logic [LW-1:0] mem_wdata, b_mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic [LW-1:0] b_mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          b_mem_ready = 1'b0;

  mem_line_arbiter #(.NCH(2), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(ARB_RR)) dut (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ready(ch_ready), .ch_rdata(ch_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_line_arbiter #(.NCH(2), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(ARB_FIXED)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ready(b_ch_ready), .ch_rdata(b_ch_rdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 3;
  logic [LW-1:0] resp_pat = '0;
  logic [LW-1:0] last_rdata = '0;
  logic b_on = 1'b0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } iss_t;
  typedef struct {
    logic [1:0]    rdy;
    logic [LW-1:0] rdata;
  } rdy_t;

  iss_t iq_a[$];
  iss_t iq_b[$];
  rdy_t rq_a[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory models: answer lat cycles after a request appears.
  int cnt_a = 0;
  int cnt_b = 0;
  always @(negedge clk) begin
    if (!rst_n || !(mem_read || mem_write)) begin
      cnt_a = 0;
      mem_ready = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else begin
      cnt_a++;
      if (cnt_a >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = resp_pat;
      end
    end
    if (!rst_n || !(b_mem_read || b_mem_write)) begin
      cnt_b = 0;
      b_mem_ready = 1'b0;
    end else if (b_mem_ready) begin
      b_mem_ready = 1'b0;
    end else begin
      cnt_b++;
      if (cnt_b >= lat) begin
        b_mem_ready = 1'b1;
        b_mem_rdata = resp_pat;
      end
    end
  end

  logic rdy_edge_a = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdy_edge_a <= mem_ready;
  end

  // Scoreboard monitors.
  logic req_prev_a = 1'b0;
  logic req_prev_b = 1'b0;
  int last_rdy_cyc = 0;
  int issue_gap = 0;
  always @(posedge clk) begin
    iss_t e;
    rdy_t r;
    #1;
    if (rst_n) begin
      if ((mem_read || mem_write) && !req_prev_a) begin
        issue_gap = cyc - last_rdy_cyc;
        if (iq_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_unexpected: got addr=%h rd=%b wr=%b want none", mem_addr,
                   mem_read, mem_write);
        end else begin
          e = iq_a.pop_front();
          chk("issue_read", LW'(mem_read), LW'(e.rd));
          chk("issue_write", LW'(mem_write), LW'(e.wr));
          chk("issue_addr", LW'(mem_addr), LW'(e.addr));
          if (e.wr) chk("issue_wdata", mem_wdata, e.wdata);
        end
      end
      // mem_ready's own cycle is the one before this sample.
      if (rdy_edge_a) last_rdy_cyc = cyc - 1;
      if (ch_ready != 0 || rdy_edge_a) begin
        chk("ready_latency", LW'(ch_ready != 0), LW'(rdy_edge_a));
      end
      if (ch_ready != 0) begin
        if (rq_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ready_unexpected: got ch_ready=%b want none", ch_ready);
        end else begin
          r = rq_a.pop_front();
          chk("ready_onehot", LW'(ch_ready), LW'(r.rdy));
          chk("ready_rdata", ch_rdata, r.rdata);
        end
      end
      if (b_on && (b_mem_read || b_mem_write) && !req_prev_b) begin
        if (iq_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fixed_issue_unexpected: got addr=%h want none", b_mem_addr);
        end else begin
          e = iq_b.pop_front();
          chk("fixed_issue_addr", LW'(b_mem_addr), LW'(e.addr));
          chk("fixed_issue_read", LW'(b_mem_read), LW'(e.rd));
        end
      end
    end
    req_prev_a = mem_read || mem_write;
    req_prev_b = b_mem_read || b_mem_write;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int ch, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (ch_ready[ch]) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got no ch_ready[%0d] want pulse within %0d cycles", name, ch, bound);
  endtask

  task automatic wait_any(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (ch_ready != 0) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got no ch_ready want pulse within %0d cycles", name, bound);
  endtask

  task automatic push_exp(input logic rd, input logic wr, input int ch, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata);
    iss_t e;
    rdy_t r;
    e.rd = rd && !wr;
    e.wr = wr;
    e.addr = addr;
    e.wdata = wdata;
    iq_a.push_back(e);
    if (e.rd) last_rdata = resp_pat;
    r.rdy = 2'(1 << ch);
    r.rdata = last_rdata;
    rq_a.push_back(r);
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    int            ch;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] resp;
    logic          exp_mr;
    logic          exp_mw;
    logic [1:0]    exp_rdy;
    logic [LW-1:0] exp_rdata;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    iss_t e;
    rdy_t r;
    tbl[0] = '{1'b1, 1'b0, 0, 28'h0000040, 128'h0, {16{8'hA5}}, 1'b1, 1'b0, 2'b01,
               {16{8'hA5}}};
    tbl[1] = '{1'b1, 1'b0, 1, 28'h0000123, 128'h0, {16{8'h5A}}, 1'b1, 1'b0, 2'b10,
               {16{8'h5A}}};
    tbl[2] = '{1'b0, 1'b1, 0, 28'h0000077, 128'hBEEF, {16{8'hFF}}, 1'b0, 1'b1, 2'b01,
               {16{8'h5A}}};
    tbl[3] = '{1'b1, 1'b1, 1, 28'h0000088, 128'h1234, {16{8'hEE}}, 1'b0, 1'b1, 2'b10,
               {16{8'h5A}}};
    tbl[4] = '{1'b1, 1'b0, 1, 28'h0000088, 128'h0, {16{8'hC3}}, 1'b1, 1'b0, 2'b10,
               {16{8'hC3}}};
    tbl[5] = '{1'b0, 1'b1, 0, 28'h0000009, 128'hDEAD, {16{8'h11}}, 1'b0, 1'b1, 2'b01,
               {16{8'hC3}}};

    // Reset state.
    repeat (3) cycle();
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_write", LW'(mem_write), '0);
    chk("rst_ch_ready", LW'(ch_ready), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_ch_rdata", ch_rdata, '0);
    rst_n = 1'b1;
    cycle();

    // Single transactions, one per vector.
    for (int i = 0; i < 6; i++) begin
      resp_pat = tbl[i].resp;
      e = '{tbl[i].exp_mr, tbl[i].exp_mw, tbl[i].addr, tbl[i].wdata};
      iq_a.push_back(e);
      r = '{tbl[i].exp_rdy, tbl[i].exp_rdata};
      rq_a.push_back(r);
      last_rdata = tbl[i].exp_rdata;
      ch_read[tbl[i].ch] = tbl[i].rd;
      ch_write[tbl[i].ch] = tbl[i].wr;
      ch_addr[tbl[i].ch*AW +: AW] = tbl[i].addr;
      ch_wdata[tbl[i].ch*LW +: LW] = tbl[i].wdata;
      wait_rdy(tbl[i].ch, 30, "vec_ready");
      ch_read = '0;
      ch_write = '0;
      cycle();
      cycle();
    end

    // Address change while busy must not reach memory.
    resp_pat = {8{16'h7E57}};
    push_exp(1'b1, 1'b0, 0, 28'h10, '0);
    ch_addr[0 +: AW] = 28'h10;
    ch_read[0] = 1'b1;
    for (int i = 0; i < 10 && !mem_read; i++) cycle();
    ch_addr[0 +: AW] = 28'h20;
    for (int i = 0; i < 30; i++) begin
      if (mem_read) chk("busy_addr_stable", LW'(mem_addr), LW'(28'h10));
      cycle();
      if (ch_ready[0]) break;
    end
    chk("busy_ready_seen", LW'(ch_ready), LW'(2'b01));
    ch_read = '0;
    cycle();
    cycle();

    // Reset while busy; pointer was left at 1 by the last grant.
    lat = 20;
    resp_pat = {8{16'hB0B0}};
    e = '{1'b1, 1'b0, 28'h300, '0};
    iq_a.push_back(e);
    ch_addr[0 +: AW] = 28'h300;
    ch_read[0] = 1'b1;
    for (int i = 0; i < 10 && !mem_read; i++) cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", LW'(mem_read), '0);
    chk("midrst_mem_write", LW'(mem_write), '0);
    chk("midrst_ch_ready", LW'(ch_ready), '0);
    lat = 3;
    resp_pat = {8{16'h4242}};
    ch_read = 2'b11;
    ch_addr[0 +: AW] = 28'h400;
    ch_addr[AW +: AW] = 28'h500;
    push_exp(1'b1, 1'b0, 0, 28'h400, '0);
    push_exp(1'b1, 1'b0, 1, 28'h500, '0);
    cycle();
    rst_n = 1'b1;
    wait_rdy(0, 30, "rr_first_ready");
    ch_read[0] = 1'b0;
    wait_rdy(1, 30, "rr_second_ready");
    chk("rr_issue_gap", LW'(issue_gap), LW'(3));
    ch_read = '0;
    cycle();
    cycle();

    // Fairness with both channels always pending, both modes side by side.
    b_on = 1'b1;
    resp_pat = {8{16'h9999}};
    ch_addr[0 +: AW] = 28'h600;
    ch_addr[AW +: AW] = 28'h700;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b1, 1'b0, i % 2, (i % 2 == 0) ? 28'h600 : 28'h700, '0);
      e = '{1'b1, 1'b0, 28'h600, '0};
      iq_b.push_back(e);
    end
    ch_read = 2'b11;
    for (int i = 0; i < 4; i++) wait_any(30, "fair_ready");
    ch_read = '0;
    repeat (4) cycle();
    b_on = 1'b0;

    chk("drain_issue_q", LW'(iq_a.size()), '0);
    chk("drain_ready_q", LW'(rq_a.size()), '0);
    chk("drain_fixed_q", LW'(iq_b.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares one slow line-memory port among NCH cache miss channels, e.g. I-cache and D-cache in CHIP, removing the second memory bus.
- Each channel uses the same handshake a cache uses toward slow memory: read/write, line address, write data, ready, read data.
- Arbitration is round-robin or fixed-priority, and each memory transaction is held until the memory acknowledges it.
- Sits between the L1 caches and the external memory port.

Parameters:
- NCH, 2, number of requesting channels (1..8); channel 0 is the I-cache and channel 1 is the D-cache in the default build.
- ADDR_W, 28, line address width (byte address bits [31:4]).
- LINE_W, 128, line data width.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with the lowest index highest.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_read  in  NCH  per-channel line read request.
- ch_write  in  NCH  per-channel line write request.
- ch_addr  in  NCH*ADDR_W  packed line addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NCH*LINE_W  packed write lines.
- ch_ready  out  NCH  one-hot, one-cycle completion pulse per channel.
- ch_rdata  out  LINE_W  read line, valid while the matching ch_ready bit is high.
- mem_read  out  1  read request to memory.
- mem_write  out  1  write request to memory.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write line.
- mem_rdata  in  LINE_W  memory read line.
- mem_ready  in  1  memory completion.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the round-robin pointer is 0 (channel 0 is checked first). Reset is asynchronous and may occur mid-transaction; the transaction is dropped and mem_read/mem_write fall immediately.
- Channel i is pending when ch_read[i] or ch_write[i] is high.
- FSM, IDLE:
  - If any channel is pending, pick a winner g.
  - Register mem_addr, mem_wdata, mem_read and mem_write from channel g; go to BUSY.
  - mem_read/mem_write are therefore asserted on the cycle after the request is sampled.
- FSM, BUSY:
  - Hold every mem_* output stable, ignoring any change on the channel inputs.
  - When mem_ready is high: capture mem_rdata into ch_rdata, set ch_ready[g] for the next cycle only, clear mem_read/mem_write, and go to COOL.
- FSM, COOL:
  - One dead cycle so that channel g can drop its request. No new request is sampled.
  - Go to IDLE.
- Latency: request at cycle 0 and mem_ready at cycle k give ch_ready at cycle k+1. The minimum back-to-back issue spacing is 3 cycles after mem_ready.
- Read and write both high on one channel: issue a write only (mem_write=1, mem_read=0). The channel re-requests the read afterward, which is the write-back-then-refill order.
- Round-robin (ARB_MODE=0):
  - Search starts at ptr and wraps modulo NCH.
  - After a grant, ptr = (g+1) mod NCH, with wrap from NCH-1 to 0.
  - A channel that holds its request is served within NCH grants.
- Fixed priority (ARB_MODE=1): the lowest pending index wins and ptr is unused.
- Request withdrawn while BUSY: the memory transaction still completes and ch_ready[g] still pulses; the channel ignores it.
- mem_ready while IDLE or COOL: ignored.
- ch_rdata holds its last value between pulses. It is updated on read completion only; write completion still pulses ch_ready.
- NCH=1: the arbiter degenerates to a registered pass-through with the same latency.
- At most one ch_ready bit is high in any cycle.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE/BUSY/COOL;
  - LINE_W and ADDR_W defaults;
  - ARB_RR=0 and ARB_FIXED=1 constants.
- Sub-module rr_pick:
  - combinational winner select plus registered pointer, parametrised by NCH and ARB_MODE;
  - outputs a one-hot grant and a binary index.
- The top module holds the FSM, the output registers and the packed-bus slicing.

Test Plan:
- Single read: ch_read=2'b01, ch_addr[0]=28'h0000040, memory responds with 128'hA5..A5 three cycles after mem_read rises -> mem_read rises the next cycle with mem_addr=28'h0000040; ch_ready=2'b01 for one cycle with ch_rdata=128'hA5..A5.
- Simultaneous requests in round-robin mode: ch_read=2'b11 held, each channel dropping its request after its ready -> grants go ch0 then ch1; the second mem_read starts 3 cycles after the first mem_ready.
- Fairness: both channels always pending (re-requesting after ready), ARB_MODE=0 -> grant order 0,1,0,1 across 4 transactions. With ARB_MODE=1 the same stimulus gives grant order 0,0,0,0.
- Write-back then refill: ch_write[1]=ch_read[1]=1 with ch_wdata=128'h1234 -> mem_write=1, mem_read=0, mem_wdata=128'h1234. After ready and a re-request with read only, a read is issued.
- Stability: change ch_addr[0] from 28'h10 to 28'h20 while BUSY -> mem_addr stays 28'h10 until mem_ready.
- Reset in BUSY: pull rst_n low while mem_read=1 -> mem_read=0 and ch_ready=0 immediately; after release the next request is granted to ch0 first.
